pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V Lite pipeline.
- Decides each cycle which pipeline registers advance, and when the decode stage injects a control bubble (Ctrl_Mux_DE) or the IF/ID register is flushed.
- Arbitrates four stall sources: start-up, data-memory wait states, taken-branch flush and load-use hazards.
- Includes a timeout watchdog on data-memory waits.
- Sits beside the decode stage and drives the HAZARD_ctrl_o bundle and the per-stage register enables.

Parameters:
MAX_WAIT, 16, maximum number of consecutive data-memory wait cycles before error.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
CLK  in  1  clock, rising edge.
RSTn  in  1  asynchronous active-low reset.
START  in  1  run request; 0 freezes the pipeline.
ID_Rs1  in  5  rs1 of the instruction in ID.
ID_Rs2  in  5  rs2 of the instruction in ID.
EX_Rd  in  5  rd of the instruction in EX.
EX_MemRead  in  1  the instruction in EX is a load.
EX_branch_taken  in  1  the branch/jump resolved in EX is taken.
imem_ready  in  1  instruction memory returns valid data this cycle.
dmem_req  in  1  the instruction in MEM accesses data memory.
dmem_ready  in  1  data memory completes the access this cycle.
HAZARD_BP_o  out  HAZARD_ctrl_o  bundle; its Ctrl_Mux_DE field is 1 to pass ID control and 0 to insert a bubble into ID/EX.
pc_en  out  1  PC register enable.
if_id_en  out  1  IF/ID register enable.
if_id_flush  out  1  load NOP into IF/ID on this edge.
id_ex_en  out  1  ID/EX register enable.
ex_mem_en  out  1  EX/MEM register enable.
mem_wb_en  out  1  MEM/WB register enable.
err  out  1  sticky memory-timeout flag.
stall_cnt  out  CNT_W  count of cycles with pc_en=0 while in RUN or MEM_WAIT, saturating.

Behaviour:
- One clock (CLK). Reset is asynchronous, active-low (RSTn), and forces state IDLE, wait_cnt=0, stall_cnt=0, err=0.
- Outputs are Mealy (state plus current inputs); no extra latency.
- Reset output values: all enables 0, Ctrl_Mux_DE=0, if_id_flush=0.
- States: IDLE, RUN, MEM_WAIT, ERR.
- IDLE:
  - All enables 0, Ctrl_Mux_DE=0, flush 0.
  - START=1 moves to RUN on the next edge.
- RUN, default: all enables 1, Ctrl_Mux_DE=1, flush 0. Conditions are evaluated in the priority order below; only the first match applies.
  1. START=0: outputs as IDLE; next state IDLE.
  2. dmem_req=1 and dmem_ready=0: all enables 0; next state MEM_WAIT; wait_cnt is cleared.
  3. EX_branch_taken=1: pc_en=1, if_id_flush=1, Ctrl_Mux_DE=0. Load-use and imem conditions are ignored that cycle.
  4. Load-use hazard (EX_MemRead=1, EX_Rd!=0, and EX_Rd==ID_Rs1 or EX_Rd==ID_Rs2): pc_en=0, if_id_en=0, Ctrl_Mux_DE=0; EX/MEM and MEM/WB still advance. This stalls for exactly one cycle, because the load leaves EX.
  5. imem_ready=0: pc_en=0, if_id_flush=1; other stages advance.
- MEM_WAIT:
  - All enables 0, Ctrl_Mux_DE=1 (held registers keep their values).
  - dmem_ready=1: all enables 1 this cycle; next state RUN.
  - dmem_ready=0: wait_cnt increments. When wait_cnt==MAX_WAIT-1 and dmem_ready=0, next state is ERR, so at most MAX_WAIT wait cycles are allowed.
  - START=0 has no effect here; an outstanding access must complete.
- ERR:
  - All enables 0, Ctrl_Mux_DE=0, err=1.
  - Exits only through RSTn.
- stall_cnt:
  - Increments on each edge where state is RUN or MEM_WAIT and pc_en=0.
  - Holds at 2^CNT_W-1.
- Reset mid-MEM_WAIT returns to IDLE immediately; the counters clear.

Decomposition:
- my_pkg additions:
  - pipe_state_e enum (IDLE, RUN, MEM_WAIT, ERR).
  - PIPE_MAX_WAIT default constant.
  - PIPE_en_t struct grouping the five enables plus the flush.
  - Ctrl_Mux_DE stays inside the existing HAZARD_ctrl_o.
- Sub-module: load_use_detect, a combinational hazard compare producing one bit, instantiated once.

Test Plan:
1. Release RSTn with START=0 for 3 cycles, then START=1 -> enables stay 0 until the edge after START, then all 1. stall_cnt=0.
2. RUN: EX_MemRead=1, EX_Rd=5, ID_Rs2=5 -> exactly 1 cycle with pc_en=0, if_id_en=0, Ctrl_Mux_DE=0, ex_mem_en=1. Repeat with EX_Rd=0 -> no stall.
3. EX_branch_taken=1 together with a load-use match -> pc_en=1, if_id_flush=1, Ctrl_Mux_DE=0 (branch wins); stall_cnt unchanged.
4. dmem_req=1, dmem_ready=0 for 4 cycles, then 1 -> enables 0 for 4 cycles, then 1 on the ready cycle, back to RUN. stall_cnt +4 (pc_en=0 in all four wait cycles).
5. dmem_ready held 0 with MAX_WAIT=16 -> err=1 and state ERR after exactly 16 wait cycles; enables stay 0; err holds until RSTn=0.
6. Assert RSTn=0 asynchronously mid-MEM_WAIT -> outputs take their reset values before the next CLK edge; err=0, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   // Default data-memory wait limit and stall counter width.
   localparam int PIPE_MAX_WAIT = 16;
   localparam int PIPE_CNT_W    = 16;

   // Register-specifier width of the RISC-V Lite register file.
   localparam int REG_W = 5;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } pipe_state_e;

   // Per-stage register enables plus the IF/ID flush request.
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
   } PIPE_en_t;

   // Hazard control bundle seen by the decode stage.
   typedef struct packed {
      logic Ctrl_Mux_DE;
   } HAZARD_ctrl_o;

   // All five stage enables set to v, flush always cleared.
   function automatic PIPE_en_t pipe_en_fill(input logic v);
      PIPE_en_t e;
      e.pc_en       = v;
      e.if_id_en    = v;
      e.if_id_flush = 1'b0;
      e.id_ex_en    = v;
      e.ex_mem_en   = v;
      e.mem_wb_en   = v;
      return e;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and stage-control outputs back to it.
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic [REG_W-1:0] ID_Rs1;
   logic [REG_W-1:0] ID_Rs2;
   logic [REG_W-1:0] EX_Rd;
   logic             EX_MemRead;
   logic             EX_branch_taken;
   logic             imem_ready;
   logic             dmem_req;
   logic             dmem_ready;

   HAZARD_ctrl_o     HAZARD_BP_o;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;

   // Datapath side: reports hazard information, obeys the enables.
   modport master (
      output ID_Rs1, ID_Rs2, EX_Rd, EX_MemRead, EX_branch_taken,
             imem_ready, dmem_req, dmem_ready,
      input  HAZARD_BP_o, pc_en, if_id_en, if_id_flush,
             id_ex_en, ex_mem_en, mem_wb_en
   );

   // Controller side.
   modport slave (
      input  ID_Rs1, ID_Rs2, EX_Rd, EX_MemRead, EX_branch_taken,
             imem_ready, dmem_req, dmem_ready,
      output HAZARD_BP_o, pc_en, if_id_en, if_id_flush,
             id_ex_en, ex_mem_en, mem_wb_en
   );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. x0 never creates a dependency.
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   output logic             hazard
);

   logic rd_nonzero_s;
   logic rd_match_s;

   assign rd_nonzero_s = (ex_rd != {REG_W{1'b0}});
   assign rd_match_s   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
   assign hazard       = ex_mem_read && rd_nonzero_s && rd_match_s;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Outputs are Mealy:
// they depend on the current state and this cycle's hazard inputs.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = PIPE_MAX_WAIT,
   parameter int CNT_W    = PIPE_CNT_W
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             START,
   pipeline_ctrl_if.slave   hz,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int               WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   pipe_state_e       state_r;
   pipe_state_e       state_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_s;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              err_r;
   PIPE_en_t          en_s;
   logic              mux_de_s;
   logic              load_use_s;
   logic              stall_cycle_s;

   load_use_detect u_load_use (
      .id_rs1      (hz.ID_Rs1),
      .id_rs2      (hz.ID_Rs2),
      .ex_rd       (hz.EX_Rd),
      .ex_mem_read (hz.EX_MemRead),
      .hazard      (load_use_s)
   );

   // Next-state, wait counter and stage-control decode with prioritised hazards.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      en_s       = pipe_en_fill(1'b0);
      mux_de_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (START) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (!START) begin
               state_s = IDLE;
            end else if (hz.dmem_req && !hz.dmem_ready) begin
               // Freeze everything while the data access is outstanding.
               mux_de_s   = 1'b1;
               state_s    = MEM_WAIT;
               wait_cnt_s = {WAIT_W{1'b0}};
            end else if (hz.EX_branch_taken) begin
               // Redirect wins over any younger-instruction hazard.
               en_s             = pipe_en_fill(1'b1);
               en_s.if_id_flush = 1'b1;
               mux_de_s         = 1'b0;
            end else if (load_use_s) begin
               // Hold PC and IF/ID, push a bubble into ID/EX for one cycle.
               en_s          = pipe_en_fill(1'b1);
               en_s.pc_en    = 1'b0;
               en_s.if_id_en = 1'b0;
               mux_de_s      = 1'b0;
            end else if (!hz.imem_ready) begin
               // No fetch data: keep PC, feed a NOP into IF/ID.
               en_s             = pipe_en_fill(1'b1);
               en_s.pc_en       = 1'b0;
               en_s.if_id_flush = 1'b1;
               mux_de_s         = 1'b1;
            end else begin
               en_s     = pipe_en_fill(1'b1);
               mux_de_s = 1'b1;
            end
         end
         MEM_WAIT: begin
            // START is ignored here: the outstanding access must finish.
            mux_de_s = 1'b1;
            if (hz.dmem_ready) begin
               en_s    = pipe_en_fill(1'b1);
               state_s = RUN;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_s = ERR;
            end else begin
               wait_cnt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
         end
         ERR: begin
            state_s = ERR;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign stall_cycle_s = ((state_r == RUN) || (state_r == MEM_WAIT)) && !en_s.pc_en;

   // State and wait-cycle counter registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r    <= IDLE;
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
      end
   end

   // Saturating count of cycles lost to PC stalls while running.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_cycle_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         err_r <= 1'b0;
      end else if (state_s == ERR) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign hz.pc_en                   = en_s.pc_en;
   assign hz.if_id_en                = en_s.if_id_en;
   assign hz.if_id_flush             = en_s.if_id_flush;
   assign hz.id_ex_en                = en_s.id_ex_en;
   assign hz.ex_mem_en               = en_s.ex_mem_en;
   assign hz.mem_wb_en               = en_s.mem_wb_en;
   assign hz.HAZARD_BP_o.Ctrl_Mux_DE = mux_de_s;
   assign err                        = err_r;
   assign stall_cnt                  = stall_cnt_r;

endmodule
